sseg_scan4: RTL
===============

SSEG_SCAN4 -- requirements
Module: sseg_scan4

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clki cycles each digit is lit (1 kHz/digit at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter GAP_CYC, default 500, all-digits-off anti-ghost cycles between digits; 0 means no gap.
REQ-003 SHALL have port clki  in  1  system clock; single clock domain, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  in  1  scan enable; low blanks the display.
REQ-006 SHALL have port load  in  1  one-cycle strobe capturing bcd_in and dp_mask.
REQ-007 SHALL have port bcd_in  in  16  four BCD nibbles, [3:0]=digit0 (rightmost) .. [15:12]=digit3.
REQ-008 SHALL have port dp_mask  in  4  decimal point request per digit, bit i = digit i.
REQ-009 SHALL have port blank_lz  in  1  leading-zero blanking enable (level, sampled every cycle).
REQ-010 SHALL have port sseg  out  7  segments, bit6=g .. bit0=a, active-low.
REQ-011 SHALL have port an  out  4  digit enables, active-low, bit i = digit i.
REQ-012 SHALL have port dp_n  out  1  decimal point, active-low.

Function
REQ-013 SHALL hold a shadow register (value+dp) written on load, plus a pending flag set by load.
REQ-014 SHALL transfer shadow to display register and clear pending only at frame boundary (GAP/SHOW exit of digit 3 to digit 0) or any cycle in OFF.
REQ-015 SHALL, on load coinciding with a frame boundary, transfer the old shadow and leave the new value pending.
REQ-016 SHALL let a later load overwrite an untransferred shadow (last load wins).
REQ-017 SHALL implement FSM OFF, SHOW, GAP; OFF->SHOW(idx=0) when en=1; SHOW->GAP after SCAN_DIV cycles (->SHOW idx+1 directly if GAP_CYC=0); GAP->SHOW idx+1 after GAP_CYC cycles; idx wraps 3->0.
REQ-018 SHALL go to OFF the cycle after en=0 from any state, clearing prescaler and idx.
REQ-019 SHALL drive in SHOW an=~(1<<idx), sseg=decode(display digit idx), dp_n=~dp[idx]; in OFF/GAP an=4'hF, sseg=7'h7F, dp_n=1.
REQ-020 SHALL register all outputs: output reflects state/idx with exactly one cycle latency.
REQ-021 SHALL decode 0..9 to 40,79,24,30,19,12,02,78,00,10 (hex); nibble values 10..15 to 3F (dash).
REQ-022 SHALL, with blank_lz=1, show 7F for digit i in 3..1 when it and all higher digits are 0; digit0 never blanked; dp still follows dp_mask on a blanked digit.
REQ-023 SHALL size the prescaler to clog2(max(SCAN_DIV,GAP_CYC)) and reuse it for both SHOW and GAP timing.

Reset
REQ-024 SHALL, while rst=1, force state OFF, idx=0, prescaler=0, shadow/display=0, dp=0, pending=0, an=4'hF, sseg=7'h7F, dp_n=1.
REQ-025 SHALL discard a load asserted in the same cycle as rst; first release cycle with en=1 moves to SHOW.

Structure
REQ-026 SHALL place SEG_BLANK(7F), SEG_DASH(3F), digit code table and FSM state encodings in shared package sseg_pkg.
REQ-027 SHALL instantiate one combinational sub-module seg7_dec (4-bit in, 7-bit active-low out, dash for >9).

Verification (SCAN_DIV=4, GAP_CYC=1, 50 MHz clki)
REQ-028 Reset then en=1, load bcd_in=16'h1234 with no prior frame -> display 0000 until first frame boundary, then an 1110/1101/1011/0111 show 19,30,24,79; 4 lit + 1 dark cycle each.
REQ-029 blank_lz=1, load 16'h0070 -> digit3,2 7F; digit1 78; digit0 40; blank_lz=0 -> digit3,2 show 40.
REQ-030 load 16'h00AF with dp_mask=4'b0100 -> digits1,0 show 3F; dp_n=0 only while an=1011.
REQ-031 load 16'h1111 mid-frame then 16'h2222 before boundary -> only 2222 ever appears; load at exact boundary cycle -> old value shown one frame, new next frame.
REQ-032 en dropped during SHOW of digit2 -> one cycle later an=F, sseg=7F; en re-raised -> restarts at digit0 with full SCAN_DIV period.
REQ-033 rst pulsed mid-SHOW -> outputs to an=F, sseg=7F, dp_n=1 without clock edge; display returns 0000 on resume.

Source files
------------

// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
// Shared definitions for the 4-digit multiplexed seven-segment scanner:
//   - scan FSM state encoding
//   - active-low segment codes (bit6=g .. bit0=a) for blank, dash and 0..9
//   - small elaboration-time helper for sizing the shared prescaler
// No ports (package).
// -----------------------------------------------------------------------------
package sseg_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_t;

    // Active-low segment patterns
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Digit code table, element [k] is the pattern for decimal digit k
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Larger of two integers, used to size the shared prescaler
    function automatic int pmax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : sseg_pkg

// File: rtl/sseg_scan4_seg7_dec.sv
// -----------------------------------------------------------------------------
// seg7_dec
// Combinational BCD to seven-segment decoder, active-low outputs.
// Values 10..15 are shown as a dash so corrupted BCD is visible on the display.
// Ports:
//   i_bcd [3:0]  nibble to decode
//   o_seg [6:0]  segments, bit6=g .. bit0=a, active-low
// -----------------------------------------------------------------------------
module seg7_dec
    import sseg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Table lookup with dash for non-decimal nibbles
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_DIGIT[0];
            4'd1:    o_seg = SEG_DIGIT[1];
            4'd2:    o_seg = SEG_DIGIT[2];
            4'd3:    o_seg = SEG_DIGIT[3];
            4'd4:    o_seg = SEG_DIGIT[4];
            4'd5:    o_seg = SEG_DIGIT[5];
            4'd6:    o_seg = SEG_DIGIT[6];
            4'd7:    o_seg = SEG_DIGIT[7];
            4'd8:    o_seg = SEG_DIGIT[8];
            4'd9:    o_seg = SEG_DIGIT[9];
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule : seg7_dec

// File: rtl/sseg_scan4.sv
// -----------------------------------------------------------------------------
// sseg_scan4
// Four-digit multiplexed seven-segment display scanner with double-buffered
// value, per-digit decimal points, optional leading-zero blanking and an
// all-dark anti-ghosting gap between digits.
// Parameters:
//   SCAN_DIV  clki cycles each digit is lit (2 .. 2^20)
//   GAP_CYC   dark cycles between digits (0 = no gap)
// Ports:
//   clki           system clock, rising edge
//   rst            asynchronous active-high reset
//   en             scan enable, low blanks the display
//   load           one-cycle strobe capturing bcd_in / dp_mask into the shadow
//   bcd_in [15:0]  four BCD digits, [3:0] = digit0 (rightmost)
//   dp_mask [3:0]  decimal point request, bit i = digit i
//   blank_lz       leading-zero blanking enable (level)
//   sseg [6:0]     segments, bit6=g .. bit0=a, active-low
//   an [3:0]       digit enables, active-low, bit i = digit i
//   dp_n           decimal point, active-low
// -----------------------------------------------------------------------------
module sseg_scan4
    import sseg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 500
) (
    input  logic        clki,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    output logic [6:0]  sseg,
    output logic [3:0]  an,
    output logic        dp_n
);

    // One counter times both the lit and the dark phases
    localparam int PW = $clog2(pmax(SCAN_DIV, GAP_CYC));
    localparam logic [PW-1:0] SHOW_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GAP_LAST  = (GAP_CYC == 0) ? '0 : PW'(GAP_CYC - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    scan_state_t   r_state;
    logic [1:0]    r_idx;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_shadow_val;
    logic [3:0]    r_shadow_dp;
    logic [15:0]   r_disp_val;
    logic [3:0]    r_disp_dp;
    logic          r_pending;
    logic [6:0]    r_sseg;
    logic [3:0]    r_an;
    logic          r_dp_n;

    logic          w_frame_end;
    logic          w_transfer;
    logic [3:0]    w_nibble;
    logic          w_lz_blank;
    logic [6:0]    w_dec;

    // Detect the step from digit 3 back to digit 0 (via GAP, or directly when there is no gap)
    always_comb begin
        w_frame_end = 1'b0;
        if (r_idx == 2'd3) begin
            case (r_state)
                ST_GAP:  w_frame_end = (r_presc == GAP_LAST);
                ST_SHOW: w_frame_end = (GAP_CYC == 0) && (r_presc == SHOW_LAST);
                default: w_frame_end = 1'b0;
            endcase
        end else begin
            w_frame_end = 1'b0;
        end
    end

    // Shadow moves to the display only at a frame edge or while idle, so a
    // frame is never painted with a mix of old and new digits
    always_comb begin
        w_transfer = r_pending && ((r_state == ST_OFF) || (en && w_frame_end));
    end

    // Select the nibble being scanned and decide whether it is a leading zero
    always_comb begin
        w_nibble   = r_disp_val[3:0];
        w_lz_blank = 1'b0;
        case (r_idx)
            2'd0: begin
                w_nibble   = r_disp_val[3:0];
                w_lz_blank = 1'b0;
            end
            2'd1: begin
                w_nibble   = r_disp_val[7:4];
                w_lz_blank = (r_disp_val[15:4] == 12'd0);
            end
            2'd2: begin
                w_nibble   = r_disp_val[11:8];
                w_lz_blank = (r_disp_val[15:8] == 8'd0);
            end
            2'd3: begin
                w_nibble   = r_disp_val[15:12];
                w_lz_blank = (r_disp_val[15:12] == 4'd0);
            end
            default: begin
                w_nibble   = 4'd0;
                w_lz_blank = 1'b0;
            end
        endcase
    end

    seg7_dec u_dec (
        .i_bcd (w_nibble),
        .o_seg (w_dec)
    );

    // Scan sequencer: OFF / SHOW / GAP with shared prescaler and digit index
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_idx   <= 2'd0;
            r_presc <= '0;
        end else if (!en) begin
            r_state <= ST_OFF;
            r_idx   <= 2'd0;
            r_presc <= '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_state <= ST_SHOW;
                    r_idx   <= 2'd0;
                    r_presc <= '0;
                end
                ST_SHOW: begin
                    if (r_presc == SHOW_LAST) begin
                        r_presc <= '0;
                        if (GAP_CYC == 0) begin
                            r_state <= ST_SHOW;
                            r_idx   <= r_idx + 2'd1;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end else begin
                        r_presc <= r_presc + PRESC_ONE;
                    end
                end
                ST_GAP: begin
                    if (r_presc == GAP_LAST) begin
                        r_presc <= '0;
                        r_state <= ST_SHOW;
                        r_idx   <= r_idx + 2'd1;
                    end else begin
                        r_presc <= r_presc + PRESC_ONE;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                    r_idx   <= 2'd0;
                    r_presc <= '0;
                end
            endcase
        end
    end

    // Double buffer: load writes the shadow (last load wins); a load landing
    // on a transfer cycle stays pending because the old shadow is what moves
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_shadow_val <= 16'd0;
            r_shadow_dp  <= 4'd0;
            r_disp_val   <= 16'd0;
            r_disp_dp    <= 4'd0;
            r_pending    <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_val <= bcd_in;
                r_shadow_dp  <= dp_mask;
            end
            if (w_transfer) begin
                r_disp_val <= r_shadow_val;
                r_disp_dp  <= r_shadow_dp;
            end
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_transfer) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Registered display drive, one cycle behind the sequencer state
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_an   <= 4'hF;
            r_sseg <= SEG_BLANK;
            r_dp_n <= 1'b1;
        end else begin
            case (r_state)
                ST_SHOW: begin
                    r_an   <= ~(4'b0001 << r_idx);
                    r_sseg <= (blank_lz && w_lz_blank) ? SEG_BLANK : w_dec;
                    r_dp_n <= ~r_disp_dp[r_idx];
                end
                default: begin
                    r_an   <= 4'hF;
                    r_sseg <= SEG_BLANK;
                    r_dp_n <= 1'b1;
                end
            endcase
        end
    end

    assign sseg = r_sseg;
    assign an   = r_an;
    assign dp_n = r_dp_n;

endmodule : sseg_scan4
